mant_mult_seq: RTL

- Iterative 24x24-bit mantissa multiplier that sits in front of the rounding stage in the single-precision FP multiplier datapath.
- Produces the normalized 24-bit mantissa, guard bit, sticky bit and exponent-increment flag that the rounding stage consumes.
- Uses a valid/ready handshake on both sides so fp_mult can sequence operands and results without fixed timing assumptions.

---
 rtl/mant_mult_seq_pkg.sv | 27 ++
 rtl/mant_mult_seq_if.sv | 35 +++
 rtl/mant_mult_seq_norm.sv | 38 +++
 rtl/mant_mult_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mant_mult_seq_pkg.sv
// ---------------------------------------------------------------------------
// mult_defs: shared definitions for the sequential mantissa multiplier.
//   MANT_W  - mantissa width including hidden bit (24 only)
//   PROD_W  - product width (2*MANT_W)
//   ITERS   - shift-add iterations per product: 24 (radix-2) or
//             12 (radix-4, when MANT_MULT_RADIX4_EN is defined)
//   CNT_W   - width of the iteration counter
//   state_t - FSM state encoding (IDLE, MULT, DONE)
// ---------------------------------------------------------------------------
package mult_defs;

    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;
`ifdef MANT_MULT_RADIX4_EN
    localparam int ITERS  = MANT_W / 2;
`else
    localparam int ITERS  = MANT_W;
`endif
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mant_mult_seq_if.sv
// ---------------------------------------------------------------------------
// mant_mult_seq_if: operand/result handshake bundle of the mantissa
// multiplier.
//   Operand side : in_valid, in_ready, mant_a, mant_b
//   Result side  : out_valid, out_ready, mant_out, guard, sticky,
//                  norm_inc, unnorm
//   modport slave  - the multiplier
//   modport master - the operand source / result consumer (fp_mult)
// ---------------------------------------------------------------------------
interface mant_mult_seq_if;
    import mult_defs::*;

    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] mant_out;
    logic              guard;
    logic              sticky;
    logic              norm_inc;
    logic              unnorm;

    modport slave (
        input  in_valid, mant_a, mant_b, out_ready,
        output in_ready, out_valid, mant_out, guard, sticky, norm_inc, unnorm
    );

    modport master (
        output in_valid, mant_a, mant_b, out_ready,
        input  in_ready, out_valid, mant_out, guard, sticky, norm_inc, unnorm
    );

endinterface

// File: rtl/mant_mult_seq_norm.sv
// ---------------------------------------------------------------------------
// mant_norm: purely combinational normalizer for a 48-bit unsigned product
// of two 24-bit mantissas. Selects the 24-bit truncated mantissa plus guard
// and sticky bits, flags a product in [2,4) and flags an unnormalized
// product. No left-shift normalization is done.
//   p_i        in  48  product
//   mant_out_o out 24  truncated mantissa
//   guard_o    out 1   first bit below the mantissa LSB
//   sticky_o   out 1   OR of all bits below guard
//   norm_inc_o out 1   product MSB set, exponent needs +1
//   unnorm_o   out 1   both top product bits clear
// ---------------------------------------------------------------------------
module mant_norm
    import mult_defs::*;
(
    input  logic [PROD_W-1:0] p_i,
    output logic [MANT_W-1:0] mant_out_o,
    output logic              guard_o,
    output logic              sticky_o,
    output logic              norm_inc_o,
    output logic              unnorm_o
);

    always_comb begin
        if (p_i[PROD_W-1]) begin
            mant_out_o = p_i[PROD_W-1:MANT_W];
            guard_o    = p_i[MANT_W-1];
            sticky_o   = |p_i[MANT_W-2:0];
        end else begin
            mant_out_o = p_i[PROD_W-2:MANT_W-1];
            guard_o    = p_i[MANT_W-2];
            sticky_o   = |p_i[MANT_W-3:0];
        end
        norm_inc_o = p_i[PROD_W-1];
        unnorm_o   = ~p_i[PROD_W-1] & ~p_i[PROD_W-2];
    end

endmodule

// File: rtl/mant_mult_seq.sv
// ---------------------------------------------------------------------------
// mant_mult_seq: iterative 24x24 unsigned mantissa multiplier feeding the
// rounding stage of the single-precision FP multiplier.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mant_mult_seq_if.slave: operand and result valid/ready handshakes
// Operation: an accepted operand pair is multiplied by shift-add, one step
// per clock, and the normalized result is held in DONE until consumed.
// A zero operand skips the iterations and completes on the accepting edge.
// Build option MANT_MULT_RADIX4_EN: consume two multiplier bits per step
// (0/1x/2x/3x multiplicand, 3x formed at acceptance), halving latency with
// bit-identical results.
// ---------------------------------------------------------------------------
module mant_mult_seq
    import mult_defs::*;
(
    input  logic          clk,
    input  logic          rst,
    mant_mult_seq_if.slave bus
);

    state_t            state_q, state_d;
    logic [PROD_W-1:0] p_q, p_d;       // product accumulator
    logic [PROD_W-1:0] a_q, a_d;       // multiplicand, pre-shifted to the current weight
    logic [MANT_W-1:0] b_q, b_d;       // remaining multiplier bits, LSB first
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PROD_W-1:0] addend;
    logic              in_ready;
    logic              out_valid;
`ifdef MANT_MULT_RADIX4_EN
    logic [PROD_W-1:0] a3_q, a3_d;     // 3x multiplicand, same weight as a_q
`endif

    logic [MANT_W-1:0] n_mant;
    logic              n_guard, n_sticky, n_inc, n_unnorm;

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        a_d       = a_q;
        b_d       = b_q;
        count_d   = count_q;
        addend    = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef MANT_MULT_RADIX4_EN
        a3_d      = a3_q;
`endif
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    p_d     = '0;
                    count_d = '0;
                    a_d     = {{MANT_W{1'b0}}, bus.mant_a};
                    b_d     = bus.mant_b;
`ifdef MANT_MULT_RADIX4_EN
                    a3_d    = {{MANT_W{1'b0}}, bus.mant_a}
                            + {{(MANT_W-1){1'b0}}, bus.mant_a, 1'b0};
`endif
                    if ((bus.mant_a == '0) || (bus.mant_b == '0))
                        state_d = DONE;
                    else
                        state_d = MULT;
                end
            end
            MULT: begin
`ifdef MANT_MULT_RADIX4_EN
                case (b_q[1:0])
                    2'b01:   addend = a_q;
                    2'b10:   addend = a_q << 1;
                    2'b11:   addend = a3_q;
                    default: addend = '0;
                endcase
                a_d  = a_q << 2;
                a3_d = a3_q << 2;
                b_d  = b_q >> 2;
`else
                addend = b_q[0] ? a_q : '0;
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
`endif
                // Full product of two 24-bit values fits in 48 bits: no carry-out.
                p_d     = p_q + addend;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(ITERS - 1))
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            count_q <= '0;
`ifdef MANT_MULT_RADIX4_EN
            a3_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            count_q <= count_d;
`ifdef MANT_MULT_RADIX4_EN
            a3_q    <= a3_d;
`endif
        end
    end

    mant_norm u_norm (
        .p_i        (p_q),
        .mant_out_o (n_mant),
        .guard_o    (n_guard),
        .sticky_o   (n_sticky),
        .norm_inc_o (n_inc),
        .unnorm_o   (n_unnorm)
    );

    // Results are only meaningful in DONE; elsewhere they are forced to 0 so
    // the outputs read as zero after reset (unnorm of a zero P would be 1).
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.mant_out  = out_valid ? n_mant   : '0;
    assign bus.guard     = out_valid & n_guard;
    assign bus.sticky    = out_valid & n_sticky;
    assign bus.norm_inc  = out_valid & n_inc;
    assign bus.unnorm    = out_valid & n_unnorm;

endmodule
